// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for a 16-bit Fibonacci LFSR stream: seeds from the data, locks, counts errors.
// Optional bit-error syndrome output enabled by defining LFSR_CHK_SYNDROME_EN.
module lfsr_seq_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 3,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt
`ifdef LFSR_CHK_SYNDROME_EN
  ,
  output logic [15:0]      err_syn
`endif
);

  // Handshake: a word is consumed on every posedge where in_valid=1; there is no backpressure.

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_THRESH);

  function automatic logic [15:0] step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  state_t           state, state_n;
  logic [15:0]      pred, pred_n;
  logic [3:0]       match_cnt, match_n;
  logic [3:0]       miss_cnt, miss_n;
  logic [ERR_W-1:0] err_n;
  logic [31:0]      word_n;
  logic             pulse_n;
  logic [15:0]      syn_q, syn_n;

  assign locked = (state == LOCKED);

  always_comb begin
    state_n = state;
    pred_n  = pred;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    err_n   = err_cnt;
    word_n  = word_cnt;
    pulse_n = 1'b0;
    syn_n   = syn_q;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          if (in_data == 16'h0000) begin
            // all-zero is the LFSR lock-up state, never a valid seed
            match_n = 4'd0;
          end else if (pred != 16'h0000 && in_data == pred) begin
            match_n = match_cnt + 4'd1;
            pred_n  = step(in_data);
            if (match_cnt + 4'd1 == LOCK_C) begin
              state_n = LOCKED;
              miss_n  = 4'd0;
              match_n = 4'd0;
            end
          end else begin
            pred_n  = step(in_data);
            match_n = 4'd0;
          end
        end
        LOCKED: begin
          word_n = word_cnt + 32'd1;
          // predictor free-runs so an isolated bad word costs one error only
          pred_n = step(pred);
          if (in_data == pred) begin
            miss_n = 4'd0;
          end else begin
            pulse_n = 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) err_n = err_cnt + 1'b1;
            miss_n = miss_cnt + 4'd1;
            syn_n  = in_data ^ pred;
            if (miss_cnt + 4'd1 == LOSS_C) begin
              state_n = SEARCH;
              match_n = 4'd0;
              pred_n  = step(in_data);
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    if (clr_cnt) begin
      err_n  = '0;
      word_n = 32'd0;
      syn_n  = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      pred      <= 16'h0000;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      err_cnt   <= '0;
      word_cnt  <= 32'd0;
      err_pulse <= 1'b0;
      syn_q     <= 16'h0000;
    end else begin
      state     <= state_n;
      pred      <= pred_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      err_cnt   <= err_n;
      word_cnt  <= word_n;
      err_pulse <= pulse_n;
      syn_q     <= syn_n;
    end
  end

`ifdef LFSR_CHK_SYNDROME_EN
  assign err_syn = syn_q;
`endif

endmodule
